// File: rtl/dcache_pkg.sv
// ---------------------------------------------------------------------------
// dcache_pkg
// Shared definitions for the direct-mapped write-through data cache
// controller:
//   - address field widths and a helper that derives the tag width from
//     the index width
//   - controller state constants (3-bit encoding) and the state type
//   - a packed view of a byte address at the default geometry
// Optional feature macro used by the slice: DCACHE_STATS_EN (hit/miss
// counters in dcache_stats, instantiated by dcache_ctrl).
// ---------------------------------------------------------------------------
package dcache_pkg;

    localparam int ADDR_BITS   = 32;
    localparam int OFFSET_W    = 2;
    localparam int DEF_INDEX_W = 4;

    // Everything above the word offset and the line index is tag.
    function automatic int tag_w(input int index_w);
        return ADDR_BITS - index_w - OFFSET_W;
    endfunction

    function automatic int index_w(input int address_width);
        return address_width;
    endfunction

    localparam int DEF_TAG_W = tag_w(DEF_INDEX_W);

    localparam int STATE_W = 3;
    typedef logic [STATE_W-1:0] state_t;

    localparam logic [2:0] ST_INIT   = 3'd0;
    localparam logic [2:0] ST_IDLE   = 3'd1;
    localparam logic [2:0] ST_LOOKUP = 3'd2;
    localparam logic [2:0] ST_MEM_RD = 3'd3;
    localparam logic [2:0] ST_MEM_WR = 3'd4;

    // Byte address split at the default geometry (16 lines).
    typedef struct packed {
        logic [DEF_TAG_W-1:0]   tag;
        logic [DEF_INDEX_W-1:0] index;
        logic [OFFSET_W-1:0]    offset;
    } addr_fields_t;

endpackage

// File: rtl/dcache_stats.sv
// ---------------------------------------------------------------------------
// dcache_stats
// Saturating read hit / read miss counters. Only instantiated when the
// DCACHE_STATS_EN macro is defined.
// Ports:
//   iCLK, iRST_N        clock, asynchronous active-low reset
//   iHit, iMiss         one-cycle pulses, one per read lookup outcome
//   oHitCnt, oMissCnt   32-bit counts, stick at 2**32-1
// ---------------------------------------------------------------------------
module dcache_stats (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        iHit,
    input  logic        iMiss,
    output logic [31:0] oHitCnt,
    output logic [31:0] oMissCnt
);

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            oHitCnt  <= '0;
            oMissCnt <= '0;
        end else begin
            if (iHit && !(&oHitCnt))
                oHitCnt <= oHitCnt + 32'd1;
            if (iMiss && !(&oMissCnt))
                oMissCnt <= oMissCnt + 32'd1;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// ---------------------------------------------------------------------------
// dcache_ctrl
// Controller for a direct-mapped, write-through, no-write-allocate data
// cache. The tag/valid/data array lives outside this block; its read port
// is registered (data for oIndex arrives one cycle later) and its write
// port writes oFill* at oIndex when oFillWe is high.
//
// Handshakes: the CPU raises iReq and holds iReq/iAddr/iWe/iWData stable
// while oStall is high; the transfer completes in the cycle oDone pulses.
// Toward memory, oMemReq and its address/data stay stable until the cycle
// iMemAck is high, which completes the transfer (ack may come in the very
// first request cycle).
//
// Ports:
//   iCLK, iRST_N                  clock, asynchronous active-low reset
//   iReq iWe iAddr iWData         CPU request
//   oStall oDone oRData           CPU response (oRData is 0 unless oDone)
//   oIndex iTag iV iData          array read port
//   oFillWe oFillV oFillTag oFillData   array write port (at oIndex)
//   oMemReq oMemWe oMemAddr oMemWData iMemAck iMemRData   memory port
//   oHitCnt oMissCnt              only with DCACHE_STATS_EN defined
//   oDbgState                     current controller state
// ---------------------------------------------------------------------------
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter  int ADDRESS_WIDTH = 4,
    parameter  int DATA_WIDTH    = 32,
    localparam int TAG_W         = tag_w(ADDRESS_WIDTH),
    localparam int IDX_W         = index_w(ADDRESS_WIDTH)
) (
    input  logic                  iCLK,
    input  logic                  iRST_N,
    // CPU side
    input  logic                  iReq,
    input  logic                  iWe,
    input  logic [31:0]           iAddr,
    input  logic [DATA_WIDTH-1:0] iWData,
    output logic                  oStall,
    output logic                  oDone,
    output logic [DATA_WIDTH-1:0] oRData,
    // array read
    output logic [IDX_W-1:0]      oIndex,
    input  logic [TAG_W-1:0]      iTag,
    input  logic                  iV,
    input  logic [DATA_WIDTH-1:0] iData,
    // array write
    output logic                  oFillWe,
    output logic                  oFillV,
    output logic [TAG_W-1:0]      oFillTag,
    output logic [DATA_WIDTH-1:0] oFillData,
    // memory side
    output logic                  oMemReq,
    output logic                  oMemWe,
    output logic [31:0]           oMemAddr,
    output logic [DATA_WIDTH-1:0] oMemWData,
    input  logic                  iMemAck,
    input  logic [DATA_WIDTH-1:0] iMemRData,
`ifdef DCACHE_STATS_EN
    output logic [31:0]           oHitCnt,
    output logic [31:0]           oMissCnt,
`endif
    output logic [STATE_W-1:0]    oDbgState
);

    state_t                state;
    logic [IDX_W-1:0]      sweep_idx;
    logic [31:0]           lat_addr;
    logic                  lat_we;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic                  lat_hit;   // lookup outcome, kept for write-hit update

    logic [TAG_W-1:0]      lat_tag;
    logic [IDX_W-1:0]      lat_idx;
    logic [31:0]           mem_addr;
    logic                  hit;

    assign lat_tag  = lat_addr[31:ADDRESS_WIDTH+2];
    assign lat_idx  = lat_addr[ADDRESS_WIDTH+1:2];
    // Memory is word addressed; the byte offset is always cleared.
    assign mem_addr = lat_addr & 32'hFFFF_FFFC;
    // Only meaningful in LOOKUP, when the array output belongs to lat_idx.
    assign hit      = iV && (iTag == lat_tag);

    assign oDbgState = state;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state     <= ST_INIT;
            sweep_idx <= '0;
            lat_addr  <= '0;
            lat_we    <= 1'b0;
            lat_wdata <= '0;
            lat_hit   <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    sweep_idx <= sweep_idx + 1'b1;
                    if (&sweep_idx)
                        state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (iReq) begin
                        lat_addr  <= iAddr;
                        lat_we    <= iWe;
                        lat_wdata <= iWData;
                        state     <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    lat_hit <= hit;
                    if (lat_we)
                        state <= ST_MEM_WR;
                    else if (hit)
                        state <= ST_IDLE;
                    else
                        state <= ST_MEM_RD;
                end
                ST_MEM_RD: if (iMemAck) state <= ST_IDLE;
                ST_MEM_WR: if (iMemAck) state <= ST_IDLE;
                default:   state <= ST_INIT;
            endcase
        end
    end

    always_comb begin
        oIndex    = lat_idx;
        oFillWe   = 1'b0;
        oFillV    = 1'b0;
        oFillTag  = lat_tag;
        oFillData = '0;
        oMemReq   = 1'b0;
        oMemWe    = 1'b0;
        oMemAddr  = '0;
        oMemWData = '0;
        oDone     = 1'b0;
        oRData    = '0;
        case (state)
            ST_INIT: begin
                oIndex   = sweep_idx;
                oFillWe  = 1'b1;
                oFillTag = '0;
            end
            // The array read is launched here so the line is ready in LOOKUP.
            ST_IDLE: oIndex = iAddr[ADDRESS_WIDTH+1:2];
            ST_LOOKUP: begin
                if (!lat_we && hit) begin
                    oDone  = 1'b1;
                    oRData = iData;
                end
            end
            ST_MEM_RD: begin
                oMemReq  = 1'b1;
                oMemAddr = mem_addr;
                if (iMemAck) begin
                    oFillWe   = 1'b1;
                    oFillV    = 1'b1;
                    oFillData = iMemRData;
                    oDone     = 1'b1;
                    oRData    = iMemRData;
                end
            end
            ST_MEM_WR: begin
                oMemReq   = 1'b1;
                oMemWe    = 1'b1;
                oMemAddr  = mem_addr;
                oMemWData = lat_wdata;
                if (iMemAck) begin
                    oDone = 1'b1;
                    // No write-allocate: only an already-present line is updated.
                    if (lat_hit) begin
                        oFillWe   = 1'b1;
                        oFillV    = 1'b1;
                        oFillData = lat_wdata;
                    end
                end
            end
            default: ;
        endcase
    end

    assign oStall = (state == ST_INIT) || (iReq && !oDone);

`ifdef DCACHE_STATS_EN
    dcache_stats u_stats (
        .iCLK     (iCLK),
        .iRST_N   (iRST_N),
        .iHit     ((state == ST_LOOKUP) && !lat_we && hit),
        .iMiss    ((state == ST_LOOKUP) && !lat_we && !hit),
        .oHitCnt  (oHitCnt),
        .oMissCnt (oMissCnt)
    );
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dcache_ctrl
// Bench for dcache_ctrl at the default geometry (16 lines, 32-bit words).
// Provides the external tag/data array (registered read) and a memory
// responder, applies a fixed vector table and random traffic, and checks
// against a line-level model of the cache (valid/tag per line, memory
// contents as the source of truth for read data).
// Define DCACHE_STATS_EN to also check the hit/miss counters.
// ---------------------------------------------------------------------------
module tb_dcache_ctrl;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int TW = 32 - AW - 2;
    localparam int NL = 1 << AW;

    logic          iCLK = 1'b0;
    logic          iRST_N = 1'b0;
    logic          iReq = 1'b0;
    logic          iWe = 1'b0;
    logic [31:0]   iAddr = '0;
    logic [DW-1:0] iWData = '0;
    logic          oStall;
    logic          oDone;
    logic [DW-1:0] oRData;
    logic [AW-1:0] oIndex;
    logic [TW-1:0] iTag;
    logic          iV;
    logic [DW-1:0] iData;
    logic          oFillWe;
    logic          oFillV;
    logic [TW-1:0] oFillTag;
    logic [DW-1:0] oFillData;
    logic          oMemReq;
    logic          oMemWe;
    logic [31:0]   oMemAddr;
    logic [DW-1:0] oMemWData;
    logic          iMemAck = 1'b0;
    logic [DW-1:0] iMemRData = '0;
    logic [2:0]    oDbgState;
`ifdef DCACHE_STATS_EN
    logic [31:0]   oHitCnt;
    logic [31:0]   oMissCnt;
`endif

    dcache_ctrl #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .iCLK      (iCLK),
        .iRST_N    (iRST_N),
        .iReq      (iReq),
        .iWe       (iWe),
        .iAddr     (iAddr),
        .iWData    (iWData),
        .oStall    (oStall),
        .oDone     (oDone),
        .oRData    (oRData),
        .oIndex    (oIndex),
        .iTag      (iTag),
        .iV        (iV),
        .iData     (iData),
        .oFillWe   (oFillWe),
        .oFillV    (oFillV),
        .oFillTag  (oFillTag),
        .oFillData (oFillData),
        .oMemReq   (oMemReq),
        .oMemWe    (oMemWe),
        .oMemAddr  (oMemAddr),
        .oMemWData (oMemWData),
        .iMemAck   (iMemAck),
        .iMemRData (iMemRData),
`ifdef DCACHE_STATS_EN
        .oHitCnt   (oHitCnt),
        .oMissCnt  (oMissCnt),
`endif
        .oDbgState (oDbgState)
    );

    // ---------------- clock ----------------
    always #5 iCLK = ~iCLK;

    // ---------------- external array (registered read) ----------------
    logic          arr_v    [NL];
    logic [TW-1:0] arr_tag  [NL];
    logic [DW-1:0] arr_data [NL];

    always @(posedge iCLK) begin
        iV    <= arr_v[oIndex];
        iTag  <= arr_tag[oIndex];
        iData <= arr_data[oIndex];
        if (oFillWe) begin
            arr_v[oIndex]    <= oFillV;
            arr_tag[oIndex]  <= oFillTag;
            arr_data[oIndex] <= oFillData;
        end
    end

    // ---------------- memory contents ----------------
    logic [31:0] env_mem [logic [29:0]];  // what the DUT wrote to memory
    logic [31:0] ref_mem [logic [29:0]];  // what the stimulus says memory holds

    function automatic logic [31:0] dflt(input logic [29:0] w);
        return ({2'b00, w} * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] env_read(input logic [31:0] a);
        if (env_mem.exists(a[31:2])) return env_mem[a[31:2]];
        return dflt(a[31:2]);
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        if (ref_mem.exists(a[31:2])) return ref_mem[a[31:2]];
        return dflt(a[31:2]);
    endfunction

    // ---------------- reference model ----------------
    logic          m_v   [NL];
    logic [TW-1:0] m_tag [NL];
    int            m_hits;
    int            m_misses;

    task automatic model_reset();
        for (int i = 0; i < NL; i++) begin
            m_v[i]   = 1'b0;
            m_tag[i] = '0;
        end
        m_hits   = 0;
        m_misses = 0;
    endtask

    // Expected outcome of one request, then update the model.
    task automatic model_apply(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               output logic exp_hit, output logic [31:0] exp_rdata);
        int          idx;
        logic [TW-1:0] tg;
        idx       = int'(addr[AW+1:2]);
        tg        = addr[31:AW+2];
        exp_hit   = m_v[idx] && (m_tag[idx] == tg);
        exp_rdata = '0;
        if (we) begin
            ref_mem[addr[31:2]] = wdata;
        end else begin
            exp_rdata = ref_read(addr);
            if (exp_hit) m_hits++;
            else begin
                m_misses++;
                m_v[idx]   = 1'b1;
                m_tag[idx] = tg;
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [DW-1:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_stats();
`ifdef DCACHE_STATS_EN
        chk("hit_cnt", 64'(oHitCnt), 64'(m_hits));
        chk("miss_cnt", 64'(oMissCnt), 64'(m_misses));
`endif
    endtask

    // ---------------- driver tasks ----------------
    // Entered and left at a falling edge.
    task automatic init_check();
        for (int i = 0; i < NL; i++) begin
            #1;
            chk("init_fill_we", 64'(oFillWe), 64'd1);
            chk("init_fill_v", 64'(oFillV), 64'd0);
            chk("init_index", 64'(oIndex), 64'(i));
            chk("init_stall", 64'(oStall), 64'd1);
            @(negedge iCLK);
        end
        #1;
        chk("idle_stall", 64'(oStall), 64'd0);
        chk("idle_fill_we", 64'(oFillWe), 64'd0);
        @(negedge iCLK);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            iReq      = 1'b0;
            iAddr     = $urandom;
            iMemAck   = 1'($urandom_range(0, 1));  // stray acks must be ignored
            iMemRData = $urandom;
            #1;
            chk("idle_done", 64'(oDone), 64'd0);
            chk("idle_rdata", 64'(oRData), 64'd0);
            chk("idle_memreq", 64'(oMemReq), 64'd0);
            chk("idle_stall", 64'(oStall), 64'd0);
            @(negedge iCLK);
        end
        iMemAck = 1'b0;
    endtask

    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input int delay, input logic exp_hit, input logic [31:0] exp_rdata);
        int            n_done, req_cnt, stall_bad, fill_cnt, exp_lat;
        logic          done, saw_req, req_we, f_v, fill_exp;
        logic [31:0]   req_addr, req_wdata, ack_data, rdata, f_data;
        logic [AW-1:0] f_idx;
        logic [TW-1:0] f_tag;
        n_done = 0; req_cnt = 0; stall_bad = 0; fill_cnt = 0;
        done = 0; saw_req = 0; req_we = 0; f_v = 0;
        req_addr = '0; req_wdata = '0; ack_data = '0; rdata = '0; f_data = '0;
        f_idx = '0; f_tag = '0;
        fill_exp = we ? exp_hit : !exp_hit;
        exp_lat  = (!we && exp_hit) ? 2 : 3 + delay;
        iReq = 1'b1; iWe = we; iAddr = addr; iWData = wdata; iMemAck = 1'b0;
        if (!we) exp_q.push_back(exp_rdata);
        for (int n = 1; n <= 60 && !done; n++) begin
            if (n > 1) @(negedge iCLK);
            iMemAck   = 1'b0;
            iMemRData = $urandom;
            if (oMemReq) begin
                if (!saw_req) begin
                    saw_req   = 1'b1;
                    req_addr  = oMemAddr;
                    req_we    = oMemWe;
                    req_wdata = oMemWData;
                end
                if (req_cnt == delay) begin
                    iMemAck = 1'b1;
                    if (oMemWe) env_mem[oMemAddr[31:2]] = oMemWData;
                    else begin
                        ack_data  = env_read(oMemAddr);
                        iMemRData = ack_data;
                    end
                end
                req_cnt++;
            end
            #1;
            if (oFillWe) begin
                fill_cnt++;
                f_idx = oIndex; f_tag = oFillTag; f_v = oFillV; f_data = oFillData;
            end
            if (oDone) begin
                done = 1'b1; n_done = n; rdata = oRData;
            end else if (!oStall) begin
                stall_bad++;
            end
        end
        chk("done_within_budget", 64'(done), 64'd1);
        if (done) begin
            chk("latency", 64'(n_done), 64'(exp_lat));
            chk("stall_while_busy", 64'(stall_bad), 64'd0);
            chk("mem_req_seen", 64'(saw_req), 64'(!(!we && exp_hit)));
            if (saw_req) begin
                chk("mem_addr", 64'(req_addr), 64'(addr & 32'hFFFF_FFFC));
                chk("mem_we", 64'(req_we), 64'(we));
                if (we) chk("mem_wdata", 64'(req_wdata), 64'(wdata));
            end
            chk("fill_count", 64'(fill_cnt), fill_exp ? 64'd1 : 64'd0);
            if (fill_exp && fill_cnt == 1) begin
                chk("fill_index", 64'(f_idx), 64'(addr[AW+1:2]));
                chk("fill_tag", 64'(f_tag), 64'(addr[31:AW+2]));
                chk("fill_v", 64'(f_v), 64'd1);
                chk("fill_data", 64'(f_data), we ? 64'(wdata) : 64'(ack_data));
            end
            if (we) chk("write_rdata", 64'(rdata), 64'd0);
            else    chk("read_rdata", 64'(rdata), 64'(exp_q.pop_front()));
        end
        @(negedge iCLK);
        iMemAck = 1'b0;
        iReq    = 1'b0;
        check_stats();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_hit;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t tbl [6];

    initial begin
        logic        h;
        logic [31:0] rd;
        logic        seen;

        tbl[0] = '{1'b0, 32'h0000_0040, 32'h0,          1'b0, 32'hDEAD_BEEF};
        tbl[1] = '{1'b0, 32'h0000_0040, 32'h0,          1'b1, 32'hDEAD_BEEF};
        tbl[2] = '{1'b1, 32'h0000_0040, 32'h1234_5678,  1'b1, 32'h0};
        tbl[3] = '{1'b0, 32'h0000_0040, 32'h0,          1'b1, 32'h1234_5678};
        tbl[4] = '{1'b0, 32'h0000_0440, 32'h0,          1'b0, 32'hCAFE_0440};
        tbl[5] = '{1'b0, 32'h0000_0040, 32'h0,          1'b0, 32'h1234_5678};

        env_mem[30'h10]  = 32'hDEAD_BEEF;  ref_mem[30'h10]  = 32'hDEAD_BEEF;
        env_mem[30'h110] = 32'hCAFE_0440;  ref_mem[30'h110] = 32'hCAFE_0440;
        model_reset();

        // reset state
        repeat (3) @(negedge iCLK);
        #1;
        chk("rst_memreq", 64'(oMemReq), 64'd0);
        chk("rst_done", 64'(oDone), 64'd0);
        chk("rst_rdata", 64'(oRData), 64'd0);
        chk("rst_stall", 64'(oStall), 64'd1);
        chk("rst_index", 64'(oIndex), 64'd0);
        @(negedge iCLK);
        iRST_N = 1'b1;
        init_check();
        check_stats();

        // directed table, back to back, memory answers after 3 cycles
        for (int i = 0; i < 6; i++) begin
            model_apply(tbl[i].we, tbl[i].addr, tbl[i].wdata, h, rd);
            do_txn(tbl[i].we, tbl[i].addr, tbl[i].wdata, 3, tbl[i].exp_hit, tbl[i].exp_rdata);
        end

        // random traffic on a small tag set to get plenty of hits and conflicts
        for (int i = 0; i < 150; i++) begin
            logic [31:0] a, wd;
            logic        we;
            logic [TW-1:0] tg;
            case ($urandom_range(0, 3))
                0: tg = 26'h0;
                1: tg = 26'h1;
                2: tg = 26'h2;
                default: tg = 26'h11;
            endcase
            a  = {tg, 4'($urandom_range(0, NL - 1)), 2'($urandom_range(0, 3))};
            we = ($urandom_range(0, 3) == 0);
            wd = $urandom;
            model_apply(we, a, wd, h, rd);
            do_txn(we, a, wd, $urandom_range(0, 4), h, rd);
            if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 2));
        end

        // reset in the middle of a refill: abandoned, then a full sweep
        iReq = 1'b1; iWe = 1'b0; iAddr = {26'h3F, 4'd5, 2'b00}; iMemAck = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            #1;
            if (oMemReq) seen = 1'b1;
            chk("pre_rst_done", 64'(oDone), 64'd0);
            @(negedge iCLK);
        end
        chk("mem_rd_reached", 64'(seen), 64'd1);
        #1;
        chk("still_in_mem_rd", 64'(oMemReq), 64'd1);
        @(negedge iCLK);
        iRST_N = 1'b0;
        #1;
        chk("rst_mid_memreq", 64'(oMemReq), 64'd0);
        chk("rst_mid_done", 64'(oDone), 64'd0);
        chk("rst_mid_fill_v", 64'(oFillV), 64'd0);
        chk("rst_mid_index", 64'(oIndex), 64'd0);
        iReq = 1'b0;
        @(negedge iCLK);
        @(negedge iCLK);
        iRST_N = 1'b1;
        model_reset();
        init_check();
        check_stats();

        // cache is empty again: everything reads from memory first
        for (int i = 0; i < 30; i++) begin
            logic [31:0] a, wd;
            logic        we;
            a  = {26'($urandom_range(0, 2)), 4'($urandom_range(0, NL - 1)), 2'b00};
            we = ($urandom_range(0, 4) == 0);
            wd = $urandom;
            model_apply(we, a, wd, h, rd);
            do_txn(we, a, wd, $urandom_range(0, 3), h, rd);
        end

        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $finish;
    end

endmodule
